// File: rtl/main_control_fsm.sv
// Multicycle main control unit: walks each instruction through fetch, decode, execute,
// memory and writeback, with a bounded wait on variable-latency memory.
module main_control_fsm #(
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [4:0]       opcode,
    input  logic [1:0]       instructionType,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic [1:0]       pc_source,
    output logic             ir_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             i_or_d,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic             alu_op_sel,
    output logic             illegal_instr,
    output logic             mem_timeout,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] retired
);

    localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC   = 4'd2,
        S_ADDR   = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWR  = 4'd5,
        S_WB_ALU = 4'd6,
        S_WB_MEM = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_TRAP   = 4'd10
    } state_t;

    state_t             state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic               is_sw_q, is_sw_d;
    logic [CNT_W-1:0]   retired_q;
    logic               retire, trap_ill, trap_to, exec_imm, waiting;
    logic [1:0]         alu_src_b_d, pc_source_d;

    logic fetch_q, mem_read_q, mem_write_q, i_or_d_q, reg_write_q, mem_to_reg_q;
    logic alu_src_a_q, alu_op_sel_q, pc_write_q, pc_write_cond_q, illegal_q, timeout_q;
    logic [1:0] alu_src_b_q, pc_source_q;

    // The zero flag steers the PC through pc_write_cond outside this block.
    logic unused_zero;
    assign unused_zero = zero;

    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        is_sw_d  = is_sw_q;
        retire   = 1'b0;
        trap_ill = 1'b0;
        trap_to  = 1'b0;
        exec_imm = 1'b0;
        waiting  = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);

        case (state_q)
            S_FETCH: if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                is_sw_d = (opcode == 5'd3);
                case (instructionType)
                    2'b00, 2'b11: begin
                        if (opcode <= 5'd3) state_d = S_EXEC;
                        else begin state_d = S_TRAP; trap_ill = 1'b1; end
                    end
                    2'b01: begin
                        case (opcode)
                            5'd0, 5'd1: begin state_d = S_EXEC; exec_imm = 1'b1; end
                            5'd2, 5'd3: state_d = S_ADDR;
                            5'd4:       state_d = S_BRANCH;
                            default:    begin state_d = S_TRAP; trap_ill = 1'b1; end
                        endcase
                    end
                    default: begin
                        if (opcode == 5'd0) state_d = S_JUMP;
                        else begin state_d = S_TRAP; trap_ill = 1'b1; end
                    end
                endcase
            end
            S_EXEC:  state_d = S_WB_ALU;
            S_ADDR:  state_d = is_sw_q ? S_MEMWR : S_MEMRD;
            S_MEMRD: if (mem_ready) state_d = S_WB_MEM;
            S_MEMWR: if (mem_ready) begin state_d = S_FETCH; retire = 1'b1; end
            S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase

        // Last wait cycle without mem_ready traps; a same-cycle mem_ready wins above.
        if (waiting && !mem_ready) begin
            if (wait_q == WAIT_W'(MAX_WAIT - 1)) begin
                state_d = S_TRAP;
                trap_to = 1'b1;
            end else begin
                wait_d = wait_q + WAIT_W'(1);
            end
        end
        if ((state_d != state_q) &&
            ((state_d == S_FETCH) || (state_d == S_MEMRD) || (state_d == S_MEMWR)))
            wait_d = '0;

        case (state_d)
            S_DECODE: alu_src_b_d = 2'b11;
            S_EXEC:   alu_src_b_d = exec_imm ? 2'b10 : 2'b00;
            S_ADDR:   alu_src_b_d = 2'b10;
            default:  alu_src_b_d = 2'b00;
        endcase
        case (state_d)
            S_BRANCH: pc_source_d = 2'b01;
            S_JUMP:   pc_source_d = 2'b10;
            default:  pc_source_d = 2'b00;
        endcase
    end

    // Outputs are registered from the next state; the reset image holds FETCH's
    // controls so the first cycle after release already requests the fetch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= S_FETCH;
            wait_q          <= '0;
            is_sw_q         <= 1'b0;
            retired_q       <= '0;
            fetch_q         <= 1'b1;
            mem_read_q      <= 1'b1;
            mem_write_q     <= 1'b0;
            i_or_d_q        <= 1'b0;
            reg_write_q     <= 1'b0;
            mem_to_reg_q    <= 1'b0;
            alu_src_a_q     <= 1'b0;
            alu_src_b_q     <= 2'b00;
            alu_op_sel_q    <= 1'b0;
            pc_write_q      <= 1'b0;
            pc_write_cond_q <= 1'b0;
            pc_source_q     <= 2'b00;
            illegal_q       <= 1'b0;
            timeout_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            wait_q          <= wait_d;
            is_sw_q         <= is_sw_d;
            if (retire) retired_q <= retired_q + CNT_W'(1);
            fetch_q         <= (state_d == S_FETCH);
            mem_read_q      <= (state_d == S_FETCH) || (state_d == S_MEMRD);
            mem_write_q     <= (state_d == S_MEMWR);
            i_or_d_q        <= (state_d == S_MEMRD) || (state_d == S_MEMWR);
            reg_write_q     <= (state_d == S_WB_ALU) || (state_d == S_WB_MEM);
            mem_to_reg_q    <= (state_d == S_WB_MEM);
            alu_src_a_q     <= (state_d == S_EXEC) || (state_d == S_ADDR) || (state_d == S_BRANCH);
            alu_src_b_q     <= alu_src_b_d;
            alu_op_sel_q    <= (state_d == S_EXEC) || (state_d == S_BRANCH);
            pc_write_q      <= (state_d == S_JUMP);
            pc_write_cond_q <= (state_d == S_BRANCH);
            pc_source_q     <= pc_source_d;
            illegal_q       <= trap_ill;
            timeout_q       <= trap_to;
        end
    end

    // Fetch completion controls follow mem_ready in the same cycle.
    assign ir_write      = reset_n & fetch_q & mem_ready;
    assign pc_write      = reset_n & (pc_write_q | (fetch_q & mem_ready));
    assign alu_src_b     = !reset_n ? 2'b00 : ((fetch_q && mem_ready) ? 2'b01 : alu_src_b_q);
    assign mem_read      = reset_n & mem_read_q;
    assign mem_write     = reset_n & mem_write_q;
    assign i_or_d        = reset_n & i_or_d_q;
    assign reg_write     = reset_n & reg_write_q;
    assign mem_to_reg    = reset_n & mem_to_reg_q;
    assign alu_src_a     = reset_n & alu_src_a_q;
    assign alu_op_sel    = reset_n & alu_op_sel_q;
    assign pc_write_cond = reset_n & pc_write_cond_q;
    assign pc_source     = reset_n ? pc_source_q : 2'b00;
    assign illegal_instr = reset_n & illegal_q;
    assign mem_timeout   = reset_n & timeout_q;
    assign state         = state_q;
    assign retired       = retired_q;

endmodule

// File: tb/tb_main_control_fsm.sv
// Bench for main_control_fsm: each instruction is expanded into its expected
// cycle-by-cycle state list, then replayed against the design.
module tb_main_control_fsm;
    localparam int MAX_WAIT = 15;
    localparam int CNT_W    = 32;

    localparam int ST_FETCH = 0, ST_DECODE = 1, ST_EXEC = 2, ST_ADDR = 3, ST_MEMRD = 4;
    localparam int ST_MEMWR = 5, ST_WB_ALU = 6, ST_WB_MEM = 7, ST_BRANCH = 8, ST_JUMP = 9;
    localparam int ST_TRAP  = 10;

    localparam int K_ALU = 0, K_LW = 1, K_SW = 2, K_BEQ = 3, K_JMP = 4, K_ILL = 5;

    logic             clk, reset_n;
    logic [4:0]       opcode;
    logic [1:0]       instructionType;
    logic             zero, mem_ready;
    logic             pc_write, pc_write_cond, ir_write, mem_read, mem_write, i_or_d;
    logic             reg_write, mem_to_reg, alu_src_a, alu_op_sel, illegal_instr, mem_timeout;
    logic [1:0]       pc_source, alu_src_b;
    logic [3:0]       state;
    logic [CNT_W-1:0] retired;

    main_control_fsm #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .instructionType(instructionType),
        .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .pc_source(pc_source), .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
        .i_or_d(i_or_d), .reg_write(reg_write), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op_sel(alu_op_sel), .illegal_instr(illegal_instr),
        .mem_timeout(mem_timeout), .state(state), .retired(retired)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int               n_cmp  = 0;
    int               n_fail = 0;
    logic [CNT_W-1:0] ret_model;
    // Scoreboard entry: {mem_ready to drive, trap cause {timeout, illegal}, state}
    logic [6:0]       exp_q[$];

    function automatic logic [15:0] ctrl_obs();
        return {pc_write, pc_write_cond, pc_source, ir_write, mem_read, mem_write, i_or_d,
                reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op_sel, illegal_instr, mem_timeout};
    endfunction

    // Control outputs each state must show, read straight off the state descriptions.
    function automatic logic [15:0] ctrl_exp(int st, logic [1:0] ty, logic rdy, logic [1:0] cause);
        logic pw, pwc, irw, mr, mw, iod, rw, m2r, asa, aop, ill, tmo;
        logic [1:0] psrc, asb;
        {pw, pwc, irw, mr, mw, iod, rw, m2r, asa, aop, ill, tmo} = '0;
        psrc = 2'b00;
        asb  = 2'b00;
        case (st)
            ST_FETCH:  begin mr = 1; if (rdy) begin irw = 1; pw = 1; asb = 2'b01; end end
            ST_DECODE: asb = 2'b11;
            ST_EXEC:   begin asa = 1; aop = 1; asb = (ty == 2'b01) ? 2'b10 : 2'b00; end
            ST_ADDR:   begin asa = 1; asb = 2'b10; end
            ST_MEMRD:  begin mr = 1; iod = 1; end
            ST_MEMWR:  begin mw = 1; iod = 1; end
            ST_WB_ALU: rw = 1;
            ST_WB_MEM: begin rw = 1; m2r = 1; end
            ST_BRANCH: begin asa = 1; aop = 1; pwc = 1; psrc = 2'b01; end
            ST_JUMP:   begin pw = 1; psrc = 2'b10; end
            ST_TRAP:   begin ill = cause[0]; tmo = cause[1]; end
            default:   ;
        endcase
        return {pw, pwc, psrc, irw, mr, mw, iod, rw, m2r, asa, asb, aop, ill, tmo};
    endfunction

    function automatic int kind_of(logic [1:0] ty, logic [4:0] op);
        case (ty)
            2'b00, 2'b11: return (op <= 5'd3) ? K_ALU : K_ILL;
            2'b01: begin
                if (op <= 5'd1) return K_ALU;
                if (op == 5'd2) return K_LW;
                if (op == 5'd3) return K_SW;
                if (op == 5'd4) return K_BEQ;
                return K_ILL;
            end
            default: return (op == 5'd0) ? K_JMP : K_ILL;
        endcase
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic push(logic rdy, logic [1:0] cause, int st);
        exp_q.push_back({rdy, cause, 4'(st)});
    endtask

    // A waiting state holds for w cycles without mem_ready, or traps after MAX_WAIT.
    task automatic push_wait(int st, int w, output logic trapped);
        trapped = 1'b0;
        if (w >= MAX_WAIT) begin
            repeat (MAX_WAIT) push(1'b0, 2'b00, st);
            push(1'($urandom_range(0, 1)), 2'b10, ST_TRAP);
            trapped = 1'b1;
        end else begin
            repeat (w) push(1'b0, 2'b00, st);
            push(1'b1, 2'b00, st);
        end
    endtask

    task automatic push_step(int st);
        push(1'($urandom_range(0, 1)), 2'b00, st);
    endtask

    // Driver: build the expected walk, then replay it one cycle per entry.
    task automatic run_instr(logic [1:0] ty, logic [4:0] op, int fw, int mw, int abort_at);
        logic       trapped, aborted;
        logic [6:0] e;
        int         idx;
        exp_q.delete();
        aborted = 1'b0;
        push_wait(ST_FETCH, fw, trapped);
        if (!trapped) begin
            push_step(ST_DECODE);
            case (kind_of(ty, op))
                K_ALU: begin push_step(ST_EXEC); push_step(ST_WB_ALU); end
                K_LW:  begin
                    push_step(ST_ADDR);
                    push_wait(ST_MEMRD, mw, trapped);
                    if (!trapped) push_step(ST_WB_MEM);
                end
                K_SW:  begin push_step(ST_ADDR); push_wait(ST_MEMWR, mw, trapped); end
                K_BEQ: push_step(ST_BRANCH);
                K_JMP: push_step(ST_JUMP);
                default: begin push(1'($urandom_range(0, 1)), 2'b01, ST_TRAP); trapped = 1'b1; end
            endcase
        end
        idx = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            #1;
            mem_ready = e[6];
            zero      = 1'($urandom_range(0, 1));
            if (int'(e[3:0]) == ST_DECODE) begin
                opcode          = op;
                instructionType = ty;
            end else begin
                opcode          = 5'($urandom_range(0, 31));
                instructionType = 2'($urandom_range(0, 3));
            end
            #1;
            check($sformatf("state[%0d]", idx), 32'(state), 32'(e[3:0]));
            check($sformatf("ctrl[%0d] st%0d", idx, e[3:0]), 32'(ctrl_obs()),
                  32'(ctrl_exp(int'(e[3:0]), ty, e[6], e[5:4])));
            check($sformatf("retired[%0d]", idx), retired, ret_model);
            if (idx == abort_at) begin
                #1 reset_n = 1'b0;
                #1;
                check("abort_mem_write", 32'(mem_write), 32'd0);
                check("abort_state", 32'(state), 32'd0);
                check("abort_ctrl", 32'(ctrl_obs()), 32'd0);
                check("abort_retired", retired, 32'd0);
                exp_q.delete();
                aborted   = 1'b1;
                ret_model = '0;
                @(posedge clk);
                #1 reset_n = 1'b1;
            end else begin
                @(posedge clk);
            end
            idx++;
        end
        if (!trapped && !aborted) ret_model = ret_model + 1;
    endtask

    initial begin
        reset_n         = 1'b0;
        opcode          = 5'd0;
        instructionType = 2'b00;
        zero            = 1'b0;
        mem_ready       = 1'b1;
        ret_model       = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_state", 32'(state), 32'd0);
        check("reset_ctrl", 32'(ctrl_obs()), 32'd0);
        check("reset_retired", retired, 32'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        run_instr(2'b00, 5'd0, 0, 0, -1);   // ADD
        run_instr(2'b01, 5'd2, 0, 3, -1);   // LW, three memory wait cycles
        run_instr(2'b01, 5'd4, 0, 0, -1);   // BEQ
        run_instr(2'b01, 5'd4, 1, 0, -1);   // BEQ again
        run_instr(2'b10, 5'd5, 0, 0, -1);   // illegal J opcode
        run_instr(2'b00, 5'd0, 15, 0, -1);  // fetch timeout
        run_instr(2'b00, 5'd1, 14, 0, -1);  // ready on the last allowed cycle
        run_instr(2'b01, 5'd2, 0, 15, -1);  // load timeout
        run_instr(2'b01, 5'd3, 0, 14, -1);  // store, last allowed cycle
        run_instr(2'b10, 5'd0, 0, 0, -1);   // jump
        run_instr(2'b11, 5'd3, 2, 0, -1);   // S-type
        run_instr(2'b00, 5'd4, 0, 0, -1);   // illegal R opcode
        run_instr(2'b01, 5'd5, 0, 0, -1);   // illegal I opcode

        for (int n = 0; n < 60; n++) begin
            logic [1:0] ty;
            logic [4:0] op;
            int         fw, mw;
            ty = 2'($urandom_range(0, 3));
            op = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 5));
            fw = ($urandom_range(0, 15) == 0) ? MAX_WAIT : $urandom_range(0, 3);
            mw = ($urandom_range(0, 9) == 0) ? MAX_WAIT : $urandom_range(0, 4);
            run_instr(ty, op, fw, mw, -1);
        end

        run_instr(2'b01, 5'd3, 0, 5, 4);    // reset during MEMWR
        run_instr(2'b00, 5'd2, 0, 0, -1);
        #1;
        check("final_retired", retired, ret_model);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
